rf_access_arbiter: RTL

- Round-robin arbiter and sequencer that shares one external 16x4 register file (single combined read/write address, asynchronous read, write on posedge) between two requesters, A and B.
- Each requester issues a single read or write transaction through a req/gnt/done handshake.
- The block owns all register-file control pins, so external write strobes can never glitch or collide.
- Optional write protection of register 0, flagged with an error pulse.

---
 rtl/rf_access_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/rf_access_arbiter.sv
// Round-robin arbiter/sequencer giving two requesters exclusive single-cycle
// access to a shared register file through an IDLE -> ACCESS -> RESP sequence.
module rf_access_arbiter #(
  parameter int AW          = 4,
  parameter int DW          = 4,
  parameter bit R0_READONLY = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_done,
  output logic [DW-1:0] a_rdata,
  output logic          a_err,

  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_done,
  output logic [DW-1:0] b_rdata,
  output logic          b_err,

  output logic [AW-1:0] rf_addr,
  output logic [DW-1:0] rf_wdata,
  output logic          rf_we,
  input  logic [DW-1:0] rf_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state, state_next;

  logic owner;       // 0 = A, 1 = B for the transaction in flight
  logic last_owner;  // requester granted most recently
  logic we_q;
  logic sup_q;       // write suppressed by register-0 protection

  logic          start;
  logic          pick_b;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          protect;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    unique case (state)
      IDLE: begin
        if (a_req || b_req) begin
          start      = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // On a tie the requester that was not granted last wins.
    pick_b    = b_req && (!a_req || !last_owner);
    sel_we    = pick_b ? b_we    : a_we;
    sel_addr  = pick_b ? b_addr  : a_addr;
    sel_wdata = pick_b ? b_wdata : a_wdata;
    protect   = R0_READONLY && (sel_addr == '0);
  end

  // Strobes are flops rather than state decodes so rf_we and the handshake
  // pulses cannot glitch.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      we_q       <= 1'b0;
      sup_q      <= 1'b0;
      a_gnt      <= 1'b0;
      b_gnt      <= 1'b0;
      a_done     <= 1'b0;
      b_done     <= 1'b0;
      a_err      <= 1'b0;
      b_err      <= 1'b0;
      a_rdata    <= '0;
      b_rdata    <= '0;
      rf_addr    <= '0;
      rf_wdata   <= '0;
      rf_we      <= 1'b0;
    end else begin
      state  <= state_next;
      a_gnt  <= 1'b0;
      b_gnt  <= 1'b0;
      a_done <= 1'b0;
      b_done <= 1'b0;
      a_err  <= 1'b0;
      b_err  <= 1'b0;
      rf_we  <= 1'b0;

      if (start) begin
        owner    <= pick_b;
        we_q     <= sel_we;
        sup_q    <= sel_we && protect;
        rf_addr  <= sel_addr;
        rf_wdata <= sel_wdata;
        rf_we    <= sel_we && !protect;
        a_gnt    <= !pick_b;
        b_gnt    <= pick_b;
      end

      if (state == ACCESS) begin
        last_owner <= owner;
        a_done     <= !owner;
        b_done     <= owner;
        a_err      <= !owner && sup_q;
        b_err      <= owner && sup_q;
        if (!we_q) begin
          if (owner) b_rdata <= rf_rdata;
          else       a_rdata <= rf_rdata;
        end
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
